// File: rtl/flippin_pkg.sv
// Shared constants and types for the falling-letter game datapath.
// Used by the letter spawner and its drop-tick generator.
package flippin_pkg;

  localparam int NUM_COLS = 3;
  localparam int LETTER_W = 8;
  localparam int SCORE_W  = 8;
  localparam int LFSR_W   = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    WAIT_GAP = 1'b0,
    ARMED    = 1'b1
  } spawn_state_t;

  // One step of the right-shifting Galois LFSR: shift down, fold taps in when a 1 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/drop_tick_gen.sv
// Global drop-step tick generator.
// The step period shrinks by TICK_STEP for every 8 points of score and is
// clamped at TICK_MIN. The period register tracks the score continuously,
// but the countdown only picks it up when it reloads, so a score change never
// shortens an interval that is already running. Registering the period also
// keeps the multiply/clamp path off the counter reload path.
module drop_tick_gen
  import flippin_pkg::*;
#(
  parameter int TICK_BASE = 25_000_000,
  parameter int TICK_MIN  = 5_000_000,
  parameter int TICK_STEP = 1_000_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               game_reset,
  input  logic [SCORE_W-1:0] score,
  output logic               drop_tick
);

  localparam logic signed [31:0] BASE_S      = $signed(32'(TICK_BASE));
  localparam logic signed [31:0] MIN_S       = $signed(32'(TICK_MIN));
  localparam logic signed [31:0] STEP_S      = $signed(32'(TICK_STEP));
  localparam logic        [31:0] BASE_U      = 32'(TICK_BASE);
  localparam logic        [31:0] BASE_RELOAD = 32'(TICK_BASE - 1);

  logic        [31:0] tick_cnt;
  logic        [31:0] period;
  logic signed [31:0] score_steps;
  logic signed [31:0] raw_period;
  logic        [31:0] target_period;

  // Score-derived period in signed 32-bit math; anything below the floor, including negatives, clamps to TICK_MIN.
  always_comb begin
    score_steps   = $signed(32'(score >> 3));
    raw_period    = BASE_S - (score_steps * STEP_S);
    target_period = (raw_period < MIN_S) ? $unsigned(MIN_S) : $unsigned(raw_period);
  end

  // Countdown, period tracking and the registered drop_tick pulse; a game restart re-arms a full base interval.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= BASE_RELOAD;
      period    <= BASE_U;
      drop_tick <= 1'b0;
    end else if (game_reset) begin
      tick_cnt  <= BASE_RELOAD;
      period    <= BASE_U;
      drop_tick <= 1'b0;
    end else begin
      period <= target_period;
      if (tick_cnt == '0) begin
        drop_tick <= 1'b1;
        tick_cnt  <= period - 32'd1;
      end else begin
        drop_tick <= 1'b0;
        tick_cnt  <= tick_cnt - 32'd1;
      end
    end
  end

endmodule

// File: rtl/letter_spawner.sv
// Upstream stage for the falling-letter columns.
// Produces pseudo-random non-zero letters from a free-running LFSR and hands
// each one to an idle column with a one-cycle one-hot spawn pulse. Columns
// are granted round-robin, and after every spawn the block waits for
// GAP_TICKS drop steps before it arms again.
module letter_spawner #(
  parameter int          NUM_COLS  = 3,
  parameter int          TICK_BASE = 25_000_000,
  parameter int          TICK_MIN  = 5_000_000,
  parameter int          TICK_STEP = 1_000_000,
  parameter int          GAP_TICKS = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              game_reset,
  input  logic [flippin_pkg::SCORE_W-1:0]   score,
  input  logic [NUM_COLS-1:0]               column_free,
  output logic [NUM_COLS-1:0]               spawn,
  output logic [flippin_pkg::LETTER_W-1:0]  letter,
  output logic                              drop_tick
);

  import flippin_pkg::*;

  localparam int PTR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [PTR_W:0]   COLS_WIDE = (PTR_W + 1)'(NUM_COLS);
  localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(NUM_COLS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

  logic [LFSR_W-1:0]   lfsr;
  logic [LETTER_W-1:0] candidate;
  logic                candidate_ok;
  spawn_state_t        state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_found;
  logic [PTR_W:0]      probe;

  drop_tick_gen #(
    .TICK_BASE (TICK_BASE),
    .TICK_MIN  (TICK_MIN),
    .TICK_STEP (TICK_STEP)
  ) u_drop_tick_gen (
    .clock      (clock),
    .reset_n    (reset_n),
    .game_reset (game_reset),
    .score      (score),
    .drop_tick  (drop_tick)
  );

  // Free-running letter source; only the hard reset reseeds it so restarts do not replay the same letters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // A letter is usable only if non-zero and different from the one most recently handed out.
  always_comb begin
    candidate    = lfsr[LETTER_W-1:0];
    candidate_ok = (candidate != '0) && (candidate != letter);
  end

  // Round-robin search from rr_ptr upward; walking offsets high-to-low lets the nearest free column win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      probe = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (probe >= COLS_WIDE) begin
        probe = probe - COLS_WIDE;
      end
      if (column_free[probe[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = probe[PTR_W-1:0];
      end
    end
  end

  // Spawn FSM: count drop ticks down to zero, then grant the first free column a valid letter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= WAIT_GAP;
      gap_cnt <= GAP_LOAD;
      rr_ptr  <= '0;
      spawn   <= '0;
      letter  <= '0;
    end else if (game_reset) begin
      state   <= WAIT_GAP;
      gap_cnt <= GAP_LOAD;
      rr_ptr  <= '0;
      spawn   <= '0;
      letter  <= '0;
    end else begin
      spawn <= '0;
      case (state)
        WAIT_GAP: begin
          if (gap_cnt == '0) begin
            state <= ARMED;
          end else if (drop_tick) begin
            gap_cnt <= gap_cnt - GAP_ONE;
            if (gap_cnt == GAP_ONE) begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (grant_found && candidate_ok) begin
            spawn[grant_idx] <= 1'b1;
            letter           <= candidate;
            rr_ptr           <= (grant_idx == LAST_COL) ? '0 : (grant_idx + PTR_W'(1));
            gap_cnt          <= GAP_LOAD;
            state            <= WAIT_GAP;
          end
        end
        default: begin
          state <= WAIT_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_letter_spawner.sv
// Self-checking bench for letter_spawner with shortened timing parameters.
// The reference model works on absolute cycle numbers: it schedules each drop
// tick from the previous one plus the period, arms after the required number
// of ticks, and steps its own copy of the LFSR to predict letters.
module tb_letter_spawner;

  localparam int TB_BASE = 10;
  localparam int TB_MIN  = 4;
  localparam int TB_STEP = 2;
  localparam int TB_GAP  = 2;
  localparam int NUM     = 3;

  logic           clock;
  logic           reset_n;
  logic           game_reset;
  logic [7:0]     score;
  logic [NUM-1:0] column_free;
  logic [NUM-1:0] spawn;
  logic [7:0]     letter;
  logic           drop_tick;

  int n_tests;
  int n_failed;

  // Reference model state.
  int             cyc;
  logic [15:0]    m_lfsr;
  int             m_next_tick;
  int             m_period;
  int             m_ticks_seen;
  bit             m_armed;
  int             m_armed_from;
  int             m_rr;
  logic [7:0]     m_letter;
  logic [NUM-1:0] m_spawn;
  logic           m_tick;

  letter_spawner #(
    .NUM_COLS  (NUM),
    .TICK_BASE (TB_BASE),
    .TICK_MIN  (TB_MIN),
    .TICK_STEP (TB_STEP),
    .GAP_TICKS (TB_GAP),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .game_reset  (game_reset),
    .score       (score),
    .column_free (column_free),
    .spawn       (spawn),
    .letter      (letter),
    .drop_tick   (drop_tick)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] galois(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic int period_for(input int s);
    int p;
    p = TB_BASE - (s / 8) * TB_STEP;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  task automatic model_reset();
    cyc          = 0;
    m_lfsr       = 16'hACE1;
    m_next_tick  = TB_BASE;
    m_period     = TB_BASE;
    m_ticks_seen = 0;
    m_armed      = 1'b0;
    m_armed_from = 0;
    m_rr         = 0;
    m_letter     = 8'h00;
    m_spawn      = '0;
    m_tick       = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [7:0]     cand;
    logic [NUM-1:0] fc;
    bit             ok;
    int             g;
    int             idx;
    cyc++;
    cand    = m_lfsr[7:0];
    m_lfsr  = galois(m_lfsr);
    m_spawn = '0;
    fc      = column_free;
    if (game_reset) begin
      m_tick       = 1'b0;
      m_next_tick  = cyc + TB_BASE;
      m_period     = TB_BASE;
      m_ticks_seen = 0;
      m_armed      = 1'b0;
      m_rr         = 0;
      m_letter     = 8'h00;
    end else begin
      if (m_armed && (cyc - 1 >= m_armed_from)) begin
        ok = (cand != 8'h00) && (cand != m_letter);
        g  = -1;
        for (int i = 0; i < NUM; i++) begin
          idx = (m_rr + i) % NUM;
          if (g < 0 && fc[idx[1:0]]) g = idx;
        end
        if (ok && g >= 0) begin
          m_spawn      = NUM'(1 << g);
          m_letter     = cand;
          m_rr         = (g + 1) % NUM;
          m_armed      = 1'b0;
          m_ticks_seen = 0;
        end
      end
      m_tick = (cyc == m_next_tick);
      if (m_tick) begin
        m_next_tick = cyc + m_period;
        if (!m_armed) begin
          m_ticks_seen++;
          if (m_ticks_seen == TB_GAP) begin
            m_armed      = 1'b1;
            m_armed_from = cyc + 1;
          end
        end
      end
      m_period = period_for(int'(score));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    game_reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int tick_cycles[$];
    score       = 8'd0;
    column_free = '0;
    game_reset  = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({spawn, letter, drop_tick} !== 12'h000) begin
      n_failed++;
      $display("[TB] FAIL reset_values got spawn=%b letter=%h tick=%b exp all zero", spawn, letter, drop_tick);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 35; i++) begin
      step();
      if (drop_tick) tick_cycles.push_back(cyc);
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL idle cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (tick_cycles.size() != 3 || tick_cycles[0] != 10 || tick_cycles[1] != 20 || tick_cycles[2] != 30) begin
      n_failed++;
      $display("[TB] FAIL base_ticks got %0d ticks first=%0d exp ticks at 10,20,30",
               tick_cycles.size(), (tick_cycles.size() > 0) ? tick_cycles[0] : -1);
    end
  endtask

  // Continues from test_reset: last tick at cycle 30, now at cycle 35.
  task automatic test_period();
    int t[$];
    int guard;
    score = 8'd16;
    guard = 0;
    while (t.size() < 6 && guard < 80) begin
      if (t.size() == 3 && score != 8'd255) score = 8'd255;
      step();
      guard++;
      if (drop_tick) t.push_back(cyc);
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL period cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (t.size() != 6) begin
      n_failed++;
      $display("[TB] FAIL period_timeout got %0d ticks exp 6", t.size());
    end else begin
      n_tests++;
      if (t[0] != 40 || t[1] != 46 || t[2] != 52) begin
        n_failed++;
        $display("[TB] FAIL period_score16 got %0d,%0d,%0d exp 40,46,52", t[0], t[1], t[2]);
      end
      n_tests++;
      if (t[3] != 58 || t[4] != 62 || t[5] != 66) begin
        n_failed++;
        $display("[TB] FAIL period_clamp got %0d,%0d,%0d exp 58,62,66", t[3], t[4], t[5]);
      end
    end
    score = 8'd0;
  endtask

  task automatic test_round_robin();
    logic [NUM-1:0] grants[$];
    logic [7:0]     letters[$];
    logic [7:0]     prev;
    int             first_cyc;
    int             guard;
    do_reset();
    column_free = 3'b111;
    score       = 8'd0;
    first_cyc   = -1;
    guard       = 0;
    while (grants.size() < 3 && guard < 200) begin
      step();
      guard++;
      if (spawn != '0) begin
        grants.push_back(spawn);
        letters.push_back(letter);
        if (first_cyc < 0) first_cyc = cyc;
      end
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL rr cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (grants.size() != 3) begin
      n_failed++;
      $display("[TB] FAIL rr_timeout got %0d spawns exp 3", grants.size());
    end else begin
      n_tests++;
      if (grants[0] !== 3'b001 || grants[1] !== 3'b010 || grants[2] !== 3'b100) begin
        n_failed++;
        $display("[TB] FAIL rr_order got %b,%b,%b exp 001,010,100", grants[0], grants[1], grants[2]);
      end
      n_tests++;
      if (first_cyc <= 20) begin
        n_failed++;
        $display("[TB] FAIL rr_first_gap got cycle %0d exp after 2nd tick at 20", first_cyc);
      end
      prev = 8'h00;
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (letters[i] == 8'h00 || letters[i] == prev) begin
          n_failed++;
          $display("[TB] FAIL rr_letter%0d got %h prev %h exp non-zero and different", i, letters[i], prev);
        end
        prev = letters[i];
      end
    end
  endtask

  task automatic test_no_free();
    int spawns_seen;
    int guard;
    do_reset();
    column_free = '0;
    spawns_seen = 0;
    for (int i = 0; i < 72; i++) begin
      step();
      if (spawn != '0) spawns_seen++;
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL nofree cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (spawns_seen != 0) begin
      n_failed++;
      $display("[TB] FAIL nofree_hold got %0d spawns exp 0", spawns_seen);
    end
    column_free = 3'b100;
    guard = 0;
    while (spawn == '0 && guard < 8) begin
      step();
      guard++;
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL nofree_late cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (spawn !== 3'b100 || letter == 8'h00) begin
      n_failed++;
      $display("[TB] FAIL nofree_grant got spawn=%b letter=%h exp spawn=100 non-zero letter", spawn, letter);
    end
  endtask

  task automatic test_game_reset();
    int first_tick;
    int first_spawn_cyc;
    logic [NUM-1:0] first_spawn;
    int guard;
    do_reset();
    column_free = '0;
    for (int i = 0; i < 29; i++) step();
    game_reset  = 1'b1;
    column_free = 3'b111;
    step();
    n_tests++;
    if (spawn !== 3'b000 || drop_tick !== 1'b0 || letter !== 8'h00) begin
      n_failed++;
      $display("[TB] FAIL greset_cycle got spawn=%b tick=%b letter=%h exp all zero", spawn, drop_tick, letter);
    end
    game_reset      = 1'b0;
    first_tick      = -1;
    first_spawn_cyc = -1;
    first_spawn     = '0;
    guard           = 0;
    while (first_spawn_cyc < 0 && guard < 60) begin
      step();
      guard++;
      if (drop_tick && first_tick < 0) first_tick = cyc;
      if (spawn != '0) begin
        first_spawn_cyc = cyc;
        first_spawn     = spawn;
      end
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL greset cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (first_tick != 40) begin
      n_failed++;
      $display("[TB] FAIL greset_tick got cycle %0d exp 40", first_tick);
    end
    n_tests++;
    if (first_spawn !== 3'b001 || first_spawn_cyc <= 50) begin
      n_failed++;
      $display("[TB] FAIL greset_spawn got %b at cycle %0d exp 001 after cycle 50", first_spawn, first_spawn_cyc);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    int tick_at;
    do_reset();
    column_free = 3'b111;
    guard = 0;
    while (spawn == '0 && guard < 60) begin
      step();
      guard++;
    end
    n_tests++;
    if (spawn == '0) begin
      n_failed++;
      $display("[TB] FAIL async_setup got no spawn in 60 cycles exp a spawn");
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({spawn, letter, drop_tick} !== 12'h000) begin
      n_failed++;
      $display("[TB] FAIL async_drop got spawn=%b letter=%h tick=%b exp all zero", spawn, letter, drop_tick);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    tick_at = -1;
    guard   = 0;
    while (guard < 60) begin
      step();
      guard++;
      if (drop_tick && tick_at < 0) tick_at = cyc;
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL async cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
    end
    n_tests++;
    if (tick_at != 10) begin
      n_failed++;
      $display("[TB] FAIL async_first_tick got cycle %0d exp 10", tick_at);
    end
  endtask

  task automatic test_random();
    do_reset();
    column_free = NUM'($urandom_range(0, 7));
    score       = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1500; i++) begin
      step();
      n_tests++;
      if ({spawn, letter, drop_tick} !== {m_spawn, m_letter, m_tick}) begin
        n_failed++;
        $display("[TB] FAIL random cyc=%0d got spawn=%b letter=%h tick=%b exp spawn=%b letter=%h tick=%b",
                 cyc, spawn, letter, drop_tick, m_spawn, m_letter, m_tick);
      end
      n_tests++;
      if ($countones(spawn) > 1) begin
        n_failed++;
        $display("[TB] FAIL random_onehot cyc=%0d got spawn=%b exp at most one bit", cyc, spawn);
      end
      if ($urandom_range(0, 7) == 0) column_free = NUM'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) score = 8'($urandom_range(0, 255));
      game_reset = ($urandom_range(0, 149) == 0);
    end
    game_reset = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_failed    = 0;
    reset_n     = 1'b0;
    game_reset  = 1'b0;
    score       = 8'd0;
    column_free = '0;
    model_reset();
    test_reset();
    test_period();
    test_round_robin();
    test_no_free();
    test_game_reset();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
